// File: rtl/priority_encoder8to3_seq.sv
// Registered 8-to-3 priority encoder with request latching.
// Pending requests are granted one index at a time over a V/ACK handshake.
module priority_encoder8to3_seq #(
  parameter int N_IN  = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             E,
  input  logic [N_IN-1:0]  D,
  input  logic             ACK,
  output logic [IDX_W-1:0] Y,
  output logic             V,
  output logic [N_IN-1:0]  PEND,
  output logic             OVF
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [N_IN-1:0]   pending, pending_nxt;
  logic [IDX_W-1:0]  y_q, y_nxt;
  logic              ovf_q, ovf_nxt;
  logic [N_IN-1:0]   set;
  logic [N_IN-1:0]   clr;
  logic [IDX_W-1:0]  top;
  logic              grant_done;

  // Highest set bit of the registered pending vector (bit 7 wins).
  always_comb begin
    top = '0;
    priority case (1'b1)
      pending[7]: top = 3'd7;
      pending[6]: top = 3'd6;
      pending[5]: top = 3'd5;
      pending[4]: top = 3'd4;
      pending[3]: top = 3'd3;
      pending[2]: top = 3'd2;
      pending[1]: top = 3'd1;
      pending[0]: top = 3'd0;
      default:    top = '0;
    endcase
  end

  // Request capture, overflow detection and FSM next state.
  // A new request on the granted bit outranks the ACK clear.
  always_comb begin
    state_nxt   = state;
    y_nxt       = y_q;
    grant_done  = (state == GRANT) && ACK;
    set         = D & {N_IN{E}};
    clr         = grant_done ? (N_IN'(1) << y_q) : '0;
    pending_nxt = (pending & ~clr) | set;
    ovf_nxt     = ovf_q | (|(set & pending & ~clr));
    unique case (state)
      IDLE: begin
        if (pending != '0) begin
          y_nxt     = top;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (ACK) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, index, pending and sticky overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      y_q     <= '0;
      pending <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      y_q     <= y_nxt;
      pending <= pending_nxt;
      ovf_q   <= ovf_nxt;
    end
  end

  assign Y    = y_q;
  assign V    = (state == GRANT);
  assign PEND = pending;
  assign OVF  = ovf_q;

endmodule
